// File: rtl/ioac_pkg.sv
// ioac_pkg: shared FC codes, FC legality check and arbiter state encoding.
`default_nettype none

package ioac_pkg;

  localparam logic [7:0] FC_R = 8'h52;
  localparam logic [7:0] FC_M = 8'h4D;
  localparam logic [7:0] FC_I = 8'h49;
  localparam logic [7:0] FC_V = 8'h56;
  localparam logic [7:0] FC_L = 8'h4C;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } arb_state_e;

  function automatic logic fc_legal(input logic [7:0] fc);
    return (fc == FC_R) || (fc == FC_M) || (fc == FC_I) ||
           (fc == FC_V) || (fc == FC_L);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ioac_cmd_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after ptr.
`default_nettype none

module rr_arbiter
  import ioac_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int pos;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    // Scan starts one past the last winner so it ends up with lowest priority.
    for (int k = 1; k <= N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IW'(pos);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ioac_cmd_arbiter.sv
// ioac_cmd_arbiter: round-robin front end sharing one IOAC controller between NREQ sources.
// Optional watchdog abort enabled by defining IOAC_ARB_TIMEOUT_EN.
`default_nettype none

module ioac_cmd_arbiter
  import ioac_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TMO_CYC = 255
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [NREQ-1:0]   Req,
  input  logic [8*NREQ-1:0] ReqFC,
  input  logic [8*NREQ-1:0] ReqOp,
  input  logic              CtlReady,
  input  logic              CtlGiveIns,
  output logic              CtlStart,
  output logic [7:0]        CtlFC,
  output logic [7:0]        CtlOpcode,
  output logic [NREQ-1:0]   Grant,
  output logic [NREQ-1:0]   InsValid,
  output logic [NREQ-1:0]   Done,
  output logic              Reject,
  output logic              Err,
  output logic [1:0]        BeatCnt,
  output logic              Busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [7:0]      fc_q, fc_d;
  logic [7:0]      op_q, op_d;
  logic [1:0]      beat_q, beat_d;
  logic            reject_q, reject_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   widx_q, widx_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [7:0]      sel_fc;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .req (Req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign sel_fc = ReqFC[{arb_idx, 3'b000} +: 8];

`ifdef IOAC_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TMO_CYC - 1);
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    fc_d     = fc_q;
    op_d     = op_q;
    beat_d   = beat_q;
    reject_d = reject_q;
    ptr_d    = ptr_q;
    widx_d   = widx_q;
`ifdef IOAC_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any && CtlReady) begin
          grant_d = arb_gnt;
          widx_d  = arb_idx;
          fc_d    = sel_fc;
          op_d    = ReqOp[{arb_idx, 3'b000} +: 8];
          beat_d  = 2'd0;
          if (fc_legal(sel_fc)) begin
            state_d = ISSUE;
          end else begin
            reject_d = 1'b1;
            state_d  = DONE;
          end
        end
      end
      ISSUE: begin
`ifdef IOAC_ARB_TIMEOUT_EN
        tmo_d = 8'd0;
`endif
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!CtlReady) state_d = WAIT_DONE;
`ifdef IOAC_ARB_TIMEOUT_EN
        tmo_d = tmo_q + 8'd1;
        if (tmo_q == TMO_LIM) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (CtlGiveIns && (beat_q != 2'd3)) beat_d = beat_q + 2'd1;
`ifdef IOAC_ARB_TIMEOUT_EN
        tmo_d = tmo_q + 8'd1;
`endif
        if (CtlReady) begin
          state_d = DONE;
`ifdef IOAC_ARB_TIMEOUT_EN
        end else if (tmo_q == TMO_LIM) begin
          state_d = DONE;
          err_d   = 1'b1;
`endif
        end
      end
      DONE: begin
        // Owner context is dropped here so IDLE always shows a clean bus.
        grant_d  = '0;
        fc_d     = 8'd0;
        op_d     = 8'd0;
        reject_d = 1'b0;
        ptr_d    = widx_q;
`ifdef IOAC_ARB_TIMEOUT_EN
        err_d    = 1'b0;
`endif
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      fc_q     <= 8'd0;
      op_q     <= 8'd0;
      beat_q   <= 2'd0;
      reject_q <= 1'b0;
      ptr_q    <= IW'(NREQ - 1);
      widx_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      fc_q     <= fc_d;
      op_q     <= op_d;
      beat_q   <= beat_d;
      reject_q <= reject_d;
      ptr_q    <= ptr_d;
      widx_q   <= widx_d;
    end
  end

`ifdef IOAC_ARB_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  assign CtlStart  = (state_q == ISSUE);
  assign CtlFC     = fc_q;
  assign CtlOpcode = op_q;
  assign Grant     = grant_q;
  assign InsValid  = (state_q == WAIT_DONE) ? (grant_q & {NREQ{CtlGiveIns}}) : '0;
  assign Done      = (state_q == DONE) ? grant_q : '0;
  assign Reject    = reject_q;
  assign BeatCnt   = beat_q;
  assign Busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ioac_cmd_arbiter.sv
// tb_ioac_cmd_arbiter: directed self-checking bench for ioac_cmd_arbiter (NREQ=4).
`default_nettype none

module tb_ioac_cmd_arbiter;

  localparam int TMO = 20;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [3:0]  Req = '0;
  logic [31:0] ReqFC = '0;
  logic [31:0] ReqOp = '0;
  logic        CtlReady = 1'b1;
  logic        CtlGiveIns = 1'b0;
  logic        CtlStart;
  logic [7:0]  CtlFC, CtlOpcode;
  logic [3:0]  Grant, InsValid, Done;
  logic        Reject, Err, Busy;
  logic [1:0]  BeatCnt;

  int total = 0;
  int passed = 0;

  ioac_cmd_arbiter #(.NREQ(4), .TMO_CYC(TMO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .ReqFC(ReqFC), .ReqOp(ReqOp),
    .CtlReady(CtlReady), .CtlGiveIns(CtlGiveIns), .CtlStart(CtlStart),
    .CtlFC(CtlFC), .CtlOpcode(CtlOpcode), .Grant(Grant), .InsValid(InsValid),
    .Done(Done), .Reject(Reject), .Err(Err), .BeatCnt(BeatCnt), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset;
    Req = '0; CtlGiveIns = 1'b0; CtlReady = 1'b1; Rst_n = 1'b0;
    tick; tick;
    Rst_n = 1'b1;
  endtask

  // Drives one legal job through the controller handshake and checks grant/start/done.
  task automatic serve(input logic [3:0] exp_g, input string name);
    int n;
    n = 0;
    while (CtlStart !== 1'b1 && n < 20) begin tick; n++; end
    total++; if (CtlStart !== 1'b1 || Grant !== exp_g) $display("FAIL %s_grant got=%b start=%b exp=%b", name, Grant, CtlStart, exp_g); else passed++;
    tick;
    CtlReady = 1'b0;
    tick;
    total++; if (CtlStart !== 1'b0 || Busy !== 1'b1) $display("FAIL %s_nostart got start=%b busy=%b exp start=0 busy=1", name, CtlStart, Busy); else passed++;
    CtlReady = 1'b1;
    tick;
    total++; if (Done !== exp_g) $display("FAIL %s_done got=%b exp=%b", name, Done, exp_g); else passed++;
    tick;
    total++; if (Done !== 4'b0000) $display("FAIL %s_done_clear got=%b exp=0000", name, Done); else passed++;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    tick;
    total++; if ({CtlStart, Grant, Done, InsValid, Reject, Err, Busy, BeatCnt} !== '0) $display("FAIL reset_outs got start=%b grant=%b done=%b busy=%b beat=%0d exp all 0", CtlStart, Grant, Done, Busy, BeatCnt); else passed++;
    total++; if ({CtlFC, CtlOpcode} !== 16'h0) $display("FAIL reset_fc got=%h exp=0000", {CtlFC, CtlOpcode}); else passed++;
    Rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_beats;
    ReqFC[7:0] = 8'h4D; ReqOp[7:0] = 8'h11; Req = 4'b0001;
    tick;
    total++; if (CtlStart !== 1'b1 || Grant !== 4'b0001) $display("FAIL t1_start got start=%b grant=%b exp 1/0001", CtlStart, Grant); else passed++;
    total++; if (CtlFC !== 8'h4D || CtlOpcode !== 8'h11 || BeatCnt !== 2'd0) $display("FAIL t1_latch got fc=%h op=%h beat=%0d exp 4d/11/0", CtlFC, CtlOpcode, BeatCnt); else passed++;
    CtlGiveIns = 1'b1; #1;
    total++; if (InsValid !== 4'b0000) $display("FAIL t1_ins_outside got=%b exp=0000", InsValid); else passed++;
    CtlGiveIns = 1'b0;
    tick;
    total++; if (CtlStart !== 1'b0 || BeatCnt !== 2'd0) $display("FAIL t1_start_once got start=%b beat=%0d exp 0/0", CtlStart, BeatCnt); else passed++;
    CtlReady = 1'b0;
    tick;
    for (int b = 0; b < 4; b++) begin
      CtlGiveIns = 1'b1; #1;
      total++; if (InsValid !== 4'b0001) $display("FAIL t1_ins_beat%0d got=%b exp=0001", b, InsValid); else passed++;
      tick;
    end
    CtlGiveIns = 1'b0;
    total++; if (BeatCnt !== 2'd3 || Done !== 4'b0000) $display("FAIL t1_beatcnt got beat=%0d done=%b exp 3/0000", BeatCnt, Done); else passed++;
    CtlReady = 1'b1;
    tick;
    total++; if (Done !== 4'b0001 || Reject !== 1'b0 || Err !== 1'b0) $display("FAIL t1_done got done=%b rej=%b err=%b exp 0001/0/0", Done, Reject, Err); else passed++;
    Req = 4'b0000;
    tick;
    total++; if (Done !== 4'b0 || Grant !== 4'b0 || CtlFC !== 8'h0 || Busy !== 1'b0 || BeatCnt !== 2'd3) $display("FAIL t1_idle got done=%b grant=%b fc=%h busy=%b beat=%0d exp 0/0/00/0/3", Done, Grant, CtlFC, Busy, BeatCnt); else passed++;
  endtask

  task automatic test_reject;
    ReqFC[23:16] = 8'h41; Req = 4'b0100;
    tick;
    total++; if (Done !== 4'b0100 || Reject !== 1'b1) $display("FAIL t3_reject got done=%b rej=%b exp 0100/1", Done, Reject); else passed++;
    total++; if (CtlStart !== 1'b0 || CtlFC !== 8'h41) $display("FAIL t3_nostart got start=%b fc=%h exp 0/41", CtlStart, CtlFC); else passed++;
    Req = 4'b0000;
    tick;
    total++; if (Done !== 4'b0 || Reject !== 1'b0 || Busy !== 1'b0) $display("FAIL t3_after got done=%b rej=%b busy=%b exp 0/0/0", Done, Reject, Busy); else passed++;
    ReqFC[23:16] = 8'h52;
  endtask

  task automatic test_fc_hold;
    ReqFC[15:8] = 8'h56; ReqOp[15:8] = 8'h33; Req = 4'b0010;
    tick;
    total++; if (CtlFC !== 8'h56 || Grant !== 4'b0010) $display("FAIL t4_latch got fc=%h grant=%b exp 56/0010", CtlFC, Grant); else passed++;
    ReqFC[15:8] = 8'h49; ReqOp[15:8] = 8'h44;
    tick;
    CtlReady = 1'b0;
    tick;
    total++; if (CtlFC !== 8'h56 || CtlOpcode !== 8'h33) $display("FAIL t4_hold got fc=%h op=%h exp 56/33", CtlFC, CtlOpcode); else passed++;
    CtlReady = 1'b1;
    tick;
    total++; if (Done !== 4'b0010 || CtlFC !== 8'h56) $display("FAIL t4_done got done=%b fc=%h exp 0010/56", Done, CtlFC); else passed++;
    Req = 4'b0000;
    tick;
    total++; if (CtlFC !== 8'h00) $display("FAIL t4_clear got fc=%h exp 00", CtlFC); else passed++;
  endtask

  task automatic test_round_robin;
    apply_reset;
    ReqFC = {4{8'h52}};
    Req = 4'b1111;
    serve(4'b0001, "t2_g0");
    serve(4'b0010, "t2_g1");
    serve(4'b0100, "t2_g2");
    serve(4'b1000, "t2_g3");
    serve(4'b0001, "t2_g0b");
    Req = 4'b0000;
  endtask

  task automatic test_back_to_back;
    Req = 4'b0010;
    serve(4'b0010, "rr_solo_a");
    serve(4'b0010, "rr_solo_b");
    Req = 4'b0011;
    serve(4'b0001, "rr_pair0");
    serve(4'b0010, "rr_pair1");
    Req = 4'b0000;
  endtask

  task automatic test_reset_midjob;
    Req = 4'b0100;
    tick; tick;
    CtlReady = 1'b0;
    tick;
    total++; if (Busy !== 1'b1 || Grant !== 4'b0100) $display("FAIL t5_inflight got busy=%b grant=%b exp 1/0100", Busy, Grant); else passed++;
    #2 Rst_n = 1'b0;
    #1;
    total++; if ({Grant, Done, Busy, CtlStart, CtlFC, Reject} !== '0) $display("FAIL t5_async got grant=%b done=%b busy=%b fc=%h exp all 0", Grant, Done, Busy, CtlFC); else passed++;
    Req = 4'b1111; CtlReady = 1'b1;
    tick;
    total++; if (Done !== 4'b0000) $display("FAIL t5_nodone got=%b exp=0000", Done); else passed++;
    Rst_n = 1'b1;
    serve(4'b0001, "t5_first");
    Req = 4'b0000;
  endtask

`ifdef IOAC_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    logic restart;
    Req = 4'b0001; CtlReady = 1'b1;
    tick;
    total++; if (CtlStart !== 1'b1) $display("FAIL t6_start got=%b exp=1", CtlStart); else passed++;
    CtlReady = 1'b0;
    n = 0; restart = 1'b0;
    while (Done === 4'b0000 && n < 200) begin
      tick; n++;
      if (CtlStart !== 1'b0) restart = 1'b1;
    end
    total++; if (n !== TMO + 1) $display("FAIL t6_cycles got=%0d exp=%0d", n, TMO + 1); else passed++;
    total++; if (Done !== 4'b0001 || Err !== 1'b1 || Reject !== 1'b0 || restart !== 1'b0) $display("FAIL t6_err got done=%b err=%b rej=%b restart=%b exp 0001/1/0/0", Done, Err, Reject, restart); else passed++;
    Req = 4'b0010; CtlReady = 1'b1;
    tick;
    total++; if (Err !== 1'b0) $display("FAIL t6_err_clear got=%b exp=0", Err); else passed++;
    tick;
    total++; if (CtlStart !== 1'b1 || Grant !== 4'b0010) $display("FAIL t6_next got start=%b grant=%b exp 1/0010", CtlStart, Grant); else passed++;
    Req = 4'b0000;
    tick; CtlReady = 1'b0;
    tick; CtlReady = 1'b1;
    tick; tick;
  endtask
`endif

  initial begin
    test_reset;
    test_single_beats;
    test_reject;
    test_fc_hold;
    test_round_robin;
    test_back_to_back;
    test_reset_midjob;
`ifdef IOAC_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
